dvi_rx_tmds_aligner: RTL and testbench
======================================

DVI_RX_TMDS_ALIGNER -- requirements
Module: dvi_rx_tmds_aligner

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 8: consecutive control tokens required to declare lock.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 4096: cycles without lock before slipping the word offset.
REQ-003 SHALL have parameter LOSS_TIMEOUT, default 65536: cycles without any control token before lock is dropped.
REQ-004 SHALL have port pixel_clock  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high; clock pixel_clock.
REQ-006 SHALL have port raw_word  input  10  unaligned deserialized word; bit 0 received earliest.
REQ-007 SHALL have port aligned_word  output  10  word-aligned TMDS symbol; bit 0 earliest, matching the transmit bit order.
REQ-008 SHALL have port locked  output  1  alignment achieved.
REQ-009 SHALL have port bit_offset  output  4  current slip offset, 0..9.
REQ-010 SHALL have port slip_pulse  output  1  one-cycle strobe on each offset change.

Function
REQ-011 SHALL register raw_word each cycle and form a 20-bit history: {current, previous}, previous in bits 9:0.
REQ-012 SHALL output aligned_word = history[bit_offset+9 : bit_offset], registered; latency 2 cycles from the raw_word sampling edge.
REQ-013 SHALL classify aligned_word as a control token when it equals 10'h354, 10'h0AB, 10'h154 or 10'h2AB.
REQ-014 SHALL run FSM states SEARCH, LOCKED; reset enters SEARCH.
REQ-015 SEARCH: run counter SHALL increment on token and clear on non-token; reaching LOCK_TOKENS SHALL enter LOCKED next cycle.
REQ-016 SEARCH: timeout counter SHALL increment every cycle; at SEARCH_TIMEOUT-1 without lock, bit_offset SHALL increment (9 wraps to 0), slip_pulse SHALL assert one cycle, and run and timeout counters SHALL clear.
REQ-017 A token completing the run on the same cycle as the timeout SHALL take priority: lock, no slip.
REQ-018 LOCKED: loss counter SHALL clear on every token and increment otherwise; at LOSS_TIMEOUT-1 the FSM SHALL return to SEARCH with counters cleared and bit_offset held.
REQ-019 bit_offset SHALL never change while LOCKED.
REQ-020 Counters SHALL saturate-free wrap only via the above clears; widths SHALL be $clog2 of their parameter.

Reset
REQ-021 On reset: aligned_word=0, locked=0, bit_offset=0, slip_pulse=0, history=0, all counters=0, FSM=SEARCH.
REQ-022 Reset mid-lock SHALL drop locked the cycle after reset is sampled.

Configuration
REQ-023 Macro DVI_RX_TMDS_DECODE_EN SHALL, when defined, add outputs data[7:0], c0, c1, de from TMDS decode of aligned_word, one extra registered cycle (latency 3).
REQ-024 Decode: word[9]=1 inverts bits 7:0; word[8]=1 uses XOR chaining, else XNOR; d[0]=q[0]; tokens map 354->c1c0=00, 0AB->01, 154->10, 2AB->11 with de=0; otherwise de=1, c0/c1 hold last value; reset all 0.
REQ-025 Without the macro, those ports and decode logic SHALL not exist; the aligner is unchanged.

Structure
REQ-026 Package dvi_tmds_pkg SHALL hold the four control-token constants and the FSM state typedef.
REQ-027 Decode SHALL be sub-module dvi_rx_tmds_decode, instantiated only under DVI_RX_TMDS_DECODE_EN.

Verification
REQ-028 Serial stream of 10'h354 repeated, shifted by 3 bits -> slips to bit_offset=3 within 3*SEARCH_TIMEOUT cycles, locked=1 after 8 aligned tokens, aligned_word=10'h354.
REQ-029 Pre-aligned stream (offset 0) with 8 tokens 10'h0AB -> locked=1 with zero slip_pulse events.
REQ-030 Locked, then 7 tokens then one data word then tokens absent for LOSS_TIMEOUT cycles -> locked stays 1 until cycle LOSS_TIMEOUT, then 0, bit_offset held.
REQ-031 Random non-token data only -> slip_pulse every SEARCH_TIMEOUT cycles, bit_offset 0..9 then wraps to 0, locked=0.
REQ-032 Assert reset while locked -> next cycle locked=0, bit_offset=0, aligned_word=0.
REQ-033 With DVI_RX_TMDS_DECODE_EN: feed TX-encoded 8'hA5 video then token 10'h2AB -> data=8'hA5, de=1; then de=0, c1=1, c0=1.

Source files
------------

// File: rtl/dvi_tmds_pkg.sv
// ---------------------------------------------------------------------------
// dvi_tmds_pkg
// Shared definitions for the DVI receive TMDS word aligner and decoder:
//   - the four TMDS control-token code words (the only symbols that can be
//     used to find word boundaries in a deserialized stream)
//   - the aligner FSM state type and its state encodings
//   - helpers for token classification and counter sizing
// ---------------------------------------------------------------------------
package dvi_tmds_pkg;

    // Control tokens, named by the {c1, c0} value they carry.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    // Aligner FSM state.
    typedef logic [0:0] aligner_state_t;
    localparam aligner_state_t ST_SEARCH = 1'b0;
    localparam aligner_state_t ST_LOCKED = 1'b1;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == CTRL_TOKEN_00) || (word == CTRL_TOKEN_01) ||
               (word == CTRL_TOKEN_10) || (word == CTRL_TOKEN_11);
    endfunction

    // Width of a counter that must hold 0 .. limit-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/dvi_rx_tmds_decode.sv
// ---------------------------------------------------------------------------
// dvi_rx_tmds_decode
// TMDS symbol decoder for one DVI channel. Only built when
// DVI_RX_TMDS_DECODE_EN is defined.
//
// Ports:
//   pixel_clock  in   clock, rising edge
//   reset        in   synchronous, active-high
//   tmds_word    in   10-bit word-aligned TMDS symbol, bit 0 earliest
//   data         out  decoded video byte (holds during control periods)
//   c0, c1       out  control bits from the last control token (hold during video)
//   de           out  1 for video symbols, 0 for control tokens
// All outputs are registered: one cycle after tmds_word.
// ---------------------------------------------------------------------------
`ifdef DVI_RX_TMDS_DECODE_EN
module dvi_rx_tmds_decode
    import dvi_tmds_pkg::*;
(
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [9:0] tmds_word,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       de
);

    logic [7:0] data_q, data_d;
    logic       c0_q, c0_d;
    logic       c1_q, c1_d;
    logic       de_q, de_d;

    // Bits 7:0 with the transmitter's DC-balance inversion (bit 9) undone.
    logic [7:0] qm;
    assign qm = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that leaves one unassigned would infer a latch.
        data_d = data_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        de_d   = 1'b1;
        case (tmds_word)
            CTRL_TOKEN_00: begin {c1_d, c0_d} = 2'b00; de_d = 1'b0; end
            CTRL_TOKEN_01: begin {c1_d, c0_d} = 2'b01; de_d = 1'b0; end
            CTRL_TOKEN_10: begin {c1_d, c0_d} = 2'b10; de_d = 1'b0; end
            CTRL_TOKEN_11: begin {c1_d, c0_d} = 2'b11; de_d = 1'b0; end
            default: begin
                // Undo the transition-minimising chain: bit 8 selects XOR vs XNOR.
                data_d[0] = qm[0];
                for (int i = 1; i < 8; i++) begin
                    data_d[i] = tmds_word[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clock) begin
        // NOTE: non-blocking assignments make every register capture pre-edge values, independent of statement order.
        if (reset) begin
            data_q <= '0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            de_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            de_q   <= de_d;
        end
    end

    assign data = data_q;
    assign c0   = c0_q;
    assign c1   = c1_q;
    assign de   = de_q;

endmodule
`endif

// File: rtl/dvi_rx_tmds_aligner.sv
// ---------------------------------------------------------------------------
// dvi_rx_tmds_aligner
// Finds the 10-bit symbol boundary in a deserialized DVI/TMDS channel by
// hunting for runs of control tokens, slipping the word offset one bit at a
// time until a run is found, then holding that offset while tokens keep
// appearing.
//
// Parameters:
//   LOCK_TOKENS     consecutive control tokens needed to declare lock
//   SEARCH_TIMEOUT  cycles spent at one offset before slipping
//   LOSS_TIMEOUT    token-free cycles tolerated while locked
//
// Ports:
//   pixel_clock   in   clock, rising edge
//   reset         in   synchronous, active-high
//   raw_word      in   unaligned deserialized word, bit 0 received earliest
//   aligned_word  out  aligned symbol, bit 0 earliest (2 cycles after raw_word)
//   locked        out  alignment achieved
//   bit_offset    out  current slip offset, 0..9
//   slip_pulse    out  one-cycle strobe on each offset change
//
// Optional build: define DVI_RX_TMDS_DECODE_EN to add the TMDS decoder
// outputs data[7:0], c0, c1, de (3 cycles after raw_word).
// ---------------------------------------------------------------------------
module dvi_rx_tmds_aligner
    import dvi_tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS    = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned LOSS_TIMEOUT   = 65536
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [9:0] raw_word,
    output logic [9:0] aligned_word,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       slip_pulse
`ifdef DVI_RX_TMDS_DECODE_EN
    ,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       de
`endif
);

    localparam int unsigned RUN_W  = cnt_width(LOCK_TOKENS);
    localparam int unsigned TOUT_W = cnt_width(SEARCH_TIMEOUT);
    localparam int unsigned LOSS_W = cnt_width(LOSS_TIMEOUT);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    // Word history: raw_q is the newest word, prev_q the one before it.
    logic [9:0]  raw_q;
    logic [9:0]  prev_q;
    logic [19:0] history;
    assign history = {raw_q, prev_q};

    logic [9:0]        aligned_q;
    logic              token;
    aligner_state_t    state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [3:0]        offset_q, offset_d;
    logic              slip_q, slip_d;

    // Tokens are classified on the registered aligned word, so an offset
    // change is first reflected in the token decision two cycles later.
    assign token = is_ctrl_token(aligned_q);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        tout_d   = tout_q;
        loss_d   = loss_q;
        offset_d = offset_q;
        slip_d   = 1'b0;
        if (state_q == ST_SEARCH) begin
            loss_d = '0;
            if (token && (run_q == RUN_LAST)) begin
                // Completing the run wins over a simultaneous timeout.
                state_d = ST_LOCKED;
                run_d   = '0;
                tout_d  = '0;
            end else if (tout_q == TOUT_LAST) begin
                offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                slip_d   = 1'b1;
                run_d    = '0;
                tout_d   = '0;
            end else begin
                tout_d = tout_q + 1'b1;
                run_d  = token ? run_q + 1'b1 : '0;
            end
        end else begin
            if (token) begin
                loss_d = '0;
            end else if (loss_q == LOSS_LAST) begin
                // Offset is kept: the search resumes from where lock was lost.
                state_d = ST_SEARCH;
                loss_d  = '0;
                run_d   = '0;
                tout_d  = '0;
            end else begin
                loss_d = loss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            raw_q     <= '0;
            prev_q    <= '0;
            aligned_q <= '0;
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            tout_q    <= '0;
            loss_q    <= '0;
            offset_q  <= '0;
            slip_q    <= 1'b0;
        end else begin
            raw_q     <= raw_word;
            prev_q    <= raw_q;
            aligned_q <= history[offset_q +: 10];
            state_q   <= state_d;
            run_q     <= run_d;
            tout_q    <= tout_d;
            loss_q    <= loss_d;
            offset_q  <= offset_d;
            slip_q    <= slip_d;
        end
    end

    assign aligned_word = aligned_q;
    assign locked       = (state_q == ST_LOCKED);
    assign bit_offset   = offset_q;
    assign slip_pulse   = slip_q;

`ifdef DVI_RX_TMDS_DECODE_EN
    dvi_rx_tmds_decode u_decode (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .tmds_word   (aligned_q),
        .data        (data),
        .c0          (c0),
        .c1          (c1),
        .de          (de)
    );
`endif

endmodule

// File: tb/tb_dvi_rx_tmds_aligner.sv
// ---------------------------------------------------------------------------
// tb_dvi_rx_tmds_aligner
// Directed bench for dvi_rx_tmds_aligner with small timeouts. Expected
// aligned words are queued when a word is driven and compared when they are
// due at the output; lock, slip and offset behaviour is checked against
// cycle counts derived from the pipeline latency.
// ---------------------------------------------------------------------------
module tb_dvi_rx_tmds_aligner;

    localparam int LOCK_TOKENS    = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int LOSS_TIMEOUT   = 256;

    logic       pixel_clock = 1'b0;
    logic       reset       = 1'b1;
    logic [9:0] raw_word    = '0;
    logic [9:0] aligned_word;
    logic       locked;
    logic [3:0] bit_offset;
    logic       slip_pulse;
`ifdef DVI_RX_TMDS_DECODE_EN
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       de;
`endif

    dvi_rx_tmds_aligner #(
        .LOCK_TOKENS    (LOCK_TOKENS),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) dut (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .raw_word     (raw_word),
        .aligned_word (aligned_word),
        .locked       (locked),
        .bit_offset   (bit_offset),
        .slip_pulse   (slip_pulse)
`ifdef DVI_RX_TMDS_DECODE_EN
        ,
        .data         (data),
        .c0           (c0),
        .c1           (c1),
        .de           (de)
`endif
    );

    always #5 pixel_clock = ~pixel_clock;

    typedef struct {
        logic [9:0] word;
        int         due;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_slip   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit is_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(1023, 0)); while (is_token(w));
        return w;
    endfunction

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        sb_entry_t e;
        @(posedge pixel_clock);
        #1;
        cyc++;
        if (slip_pulse === 1'b1) n_slip++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("aligned_word", 32'(aligned_word), 32'(e.word));
        end
    endtask

    // Drive the word for the next edge; optionally queue the aligned word
    // expected two cycles after it is sampled.
    task automatic drive(input logic [9:0] w, input bit track, input logic [9:0] expect_word);
        raw_word = w;
        if (track) sb.push_back('{word: expect_word, due: cyc + 3});
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        raw_word = '0;
        sb.delete();
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic wait_slip(input int budget, output int at, output bit seen);
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            raw_word = rand_data();
            step();
            if (slip_pulse === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
        end
    endtask

`ifdef DVI_RX_TMDS_DECODE_EN
    // Transmit-side TMDS encoding of a video byte (before DC balancing).
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [8:0] qm;
        int n1;
        n1    = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        return qm;
    endfunction
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc0;
        int         slips0;
        int         at;
        int         last;
        int         last_slip;
        bit         seen;
        bit         early;
        logic [9:0] w;

        // ---- reset state ----
        do_reset(3);
        check("reset_aligned", 32'(aligned_word), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_offset", 32'(bit_offset), 32'd0);
        check("reset_slip", 32'(slip_pulse), 32'd0);

        // ---- pre-aligned 0AB stream: lock on the 11th edge, no slips ----
        cyc0   = cyc;
        slips0 = n_slip;
        for (int i = 1; i <= 11; i++) begin
            drive(10'h0AB, 1'b1, 10'h0AB);
            step();
            if (i == 10) check("prealigned_not_yet", 32'(locked), 32'd0);
        end
        check("prealigned_locked", 32'(locked), 32'd1);
        check("prealigned_slips", 32'(n_slip - slips0), 32'd0);
        check("prealigned_offset", 32'(bit_offset), 32'd0);

        // ---- 7 tokens, then token-free data until lock is lost ----
        for (int i = 0; i < 7; i++) begin
            drive(10'h0AB, 1'b1, 10'h0AB);
            step();
        end
        early = 1'b0;
        for (int j = 1; j <= LOSS_TIMEOUT + 3; j++) begin
            w = rand_data();
            drive(w, 1'b1, w);
            step();
            if (j <= LOSS_TIMEOUT + 1 && locked !== 1'b1) early = 1'b1;
            if (j == LOSS_TIMEOUT + 2) check("loss_hold", 32'(locked), 32'd1);
        end
        check("loss_drop", 32'(locked), 32'd0);
        check("loss_no_early_drop", 32'(early), 32'd0);
        check("loss_offset_held", 32'(bit_offset), 32'd0);

        // ---- random data in SEARCH: slip every SEARCH_TIMEOUT, wrap 9 -> 0 ----
        last = cyc;
        for (int s = 1; s <= 11; s++) begin
            wait_slip(SEARCH_TIMEOUT + 4, at, seen);
            check("slip_seen", 32'(seen), 32'd1);
            check("slip_interval", 32'(at - last), 32'(SEARCH_TIMEOUT));
            check("slip_offset", 32'(bit_offset), 32'(s % 10));
            check("slip_unlocked", 32'(locked), 32'd0);
            last = seen ? at : cyc;
        end

        // ---- run completes on the timeout cycle: lock wins, no slip ----
        do_reset(2);
        cyc0   = cyc;
        slips0 = n_slip;
        for (int i = 1; i <= SEARCH_TIMEOUT; i++) begin
            w = (i >= SEARCH_TIMEOUT - 10) ? 10'h154 : 10'h000;
            drive(w, 1'b1, w);
            step();
            if (i == SEARCH_TIMEOUT - 1) check("prio_not_yet", 32'(locked), 32'd0);
        end
        check("prio_locked", 32'(locked), 32'd1);
        check("prio_no_slip", 32'(n_slip - slips0), 32'd0);
        check("prio_offset", 32'(bit_offset), 32'd0);

        // ---- 354 stream with the token starting at bit 3 ----
        do_reset(2);
        cyc0      = cyc;
        slips0    = n_slip;
        last_slip = -1;
        for (int i = 0; i < 3 * SEARCH_TIMEOUT + 20 && locked !== 1'b1; i++) begin
            drive(10'h2A6, 1'b0, 10'h000);
            step();
            if (slip_pulse === 1'b1) last_slip = cyc;
        end
        check("shift_locked", 32'(locked), 32'd1);
        check("shift_offset", 32'(bit_offset), 32'd3);
        check("shift_slips", 32'(n_slip - slips0), 32'd3);
        check("shift_slip_time", 32'(last_slip - cyc0), 32'(3 * SEARCH_TIMEOUT));
        check("shift_lock_time", 32'(cyc - last_slip), 32'(LOCK_TOKENS + 1));
        check("shift_aligned", 32'(aligned_word), 32'h354);
        for (int i = 0; i < 6; i++) begin
            drive(10'h2A6, 1'b1, 10'h354);
            step();
        end

        // ---- reset while locked ----
        check("prereset_locked", 32'(locked), 32'd1);
        reset = 1'b1;
        sb.delete();
        step();
        check("midreset_locked", 32'(locked), 32'd0);
        check("midreset_offset", 32'(bit_offset), 32'd0);
        check("midreset_aligned", 32'(aligned_word), 32'd0);
        check("midreset_slip", 32'(slip_pulse), 32'd0);
        reset = 1'b0;

`ifdef DVI_RX_TMDS_DECODE_EN
        // ---- decode: A5 video (plain then inverted form), then token 2AB ----
        begin
            logic [8:0] qm;
            logic [9:0] enc_plain;
            logic [9:0] enc_inv;
            qm        = tmds_qm(8'hA5);
            enc_plain = {1'b0, qm};
            enc_inv   = {1'b1, qm[8], ~qm[7:0]};
            do_reset(2);
            check("dec_reset_data", 32'(data), 32'd0);
            check("dec_reset_ctl", 32'({de, c1, c0}), 32'd0);
            drive(enc_plain, 1'b0, 10'h000); step();   // edge 1
            drive(enc_plain, 1'b0, 10'h000); step();   // edge 2
            drive(enc_inv, 1'b0, 10'h000);   step();   // edge 3
            drive(enc_inv, 1'b0, 10'h000);   step();   // edge 4
            check("dec_video_data", 32'(data), 32'hA5);
            check("dec_video_de", 32'(de), 32'd1);
            drive(10'h2AB, 1'b0, 10'h000);   step();   // edge 5
            step();                                     // edge 6
            check("dec_inv_data", 32'(data), 32'hA5);
            check("dec_inv_de", 32'(de), 32'd1);
            step();                                     // edge 7
            step();                                     // edge 8
            check("dec_ctl_de", 32'(de), 32'd0);
            check("dec_ctl_c1c0", 32'({c1, c0}), 32'd3);
            check("dec_ctl_data_held", 32'(data), 32'hA5);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
